ip_rx_dispatch: RTL and testbench
=================================

Name: ip_rx_dispatch

Overview:
- Receive-side IP dispatcher on the rx_clock domain, placed between the MAC/ethertype stage and the per-protocol responders (ICMP echo, UDP).
- Parses the IPv4 header byte by byte, verifies version, length, header checksum and destination address, then routes the payload to exactly one responder.
- Gates each responder's byte-enable to the IP payload only, excluding Ethernet padding.
- Drops packets when the target responder is still busy with a previous reply, and counts the drops.

Parameters:
ICMP_PROTO, 8'd1, IP protocol number routed to ICMP responder
UDP_PROTO, 8'd17, IP protocol number routed to UDP responder
CHECK_HDR_CSUM, 1, 1 = drop packets with bad header checksum; 0 = skip check

Ports:
rx_clock  in  1  receive byte clock
reset  in  1  synchronous, active-high
rx_enable  in  1  high for every byte of the IP datagram (first byte = version/IHL), contiguous
rx_data  in  8  datagram byte
local_ip  in  32  this node's IP address
icmp_busy  in  1  ICMP responder not idle (cannot accept)
udp_busy  in  1  UDP responder not idle
payload_data  out  8  registered copy of rx_data
icmp_rx_enable  out  1  payload byte valid for ICMP responder
udp_rx_enable  out  1  payload byte valid for UDP responder
remote_ip  out  32  source IP of the current or last accepted packet
is_broadcast  out  1  current packet's destination is 255.255.255.255
drop_count  out  16  saturating count of packets dropped for busy, bad checksum or bad header
hdr_error  out  1  one-cycle pulse on any header rejection

Behaviour:
- Reset: state IDLE. All enables 0, payload_data 0, remote_ip 0, is_broadcast 0, drop_count 0, hdr_error 0. Reset mid-packet aborts immediately; the remainder of the packet is discarded (DISCARD until rx_enable low).
- States: IDLE, HEADER, OPTIONS, PAYLOAD, DISCARD.
- Byte counter hdr_cnt (6 bits) indexes bytes within the header.
- IDLE, on rx_enable:
  - Require rx_data[7:4]==4 and IHL=rx_data[3:0]>=5; else DISCARD with hdr_error.
  - Otherwise latch IHL, set hdr_cnt=1, go to HEADER.
- HEADER, bytes 1..19:
  - Bytes 2-3: total_len.
  - Byte 9: protocol.
  - Bytes 12-15: src IP into a shadow register.
  - Bytes 16-19: dst IP.
  - Checksum: 32-bit sum of big-endian 16-bit words over all header bytes (even index = high byte), including options.
- Decision, evaluated combinationally on the final header byte (index IHL*4-1). At byte 19 go to OPTIONS if IHL>5; options are summed, not stored. The packet is accepted only if all hold:
  - folded sum ~(s[15:0]+s[31:16]) == 0, or CHECK_HDR_CSUM=0;
  - total_len > IHL*4;
  - dst == local_ip, or (dst == all-ones and protocol == UDP_PROTO);
  - protocol is ICMP_PROTO or UDP_PROTO;
  - the selected responder's busy input is 0 on that cycle.
- Decision outcomes:
  - Accept: next state PAYLOAD; remote_ip <= shadow src; is_broadcast updated.
  - Wrong destination or unknown protocol: DISCARD silently, no count.
  - Bad checksum, bad length or busy: DISCARD, drop_count+1 (saturates at 16'hFFFF), hdr_error pulse.
- rx_enable falls before the header ends: return to IDLE; counts as a drop with hdr_error.
- PAYLOAD:
  - Remaining-length counter rem = total_len - IHL*4, decremented per byte.
  - Selected enable is asserted with 1-cycle latency: enable(t+1)=1 and payload_data(t+1)=rx_data(t) while rem!=0.
  - When rem reaches 0 with rx_enable still high (padding), the enable drops and the state goes to DISCARD.
  - rx_enable low before rem==0 (truncated): enable deasserts one cycle later, state goes to IDLE. The responder sees the enable fall normally; no count.
- DISCARD: wait for rx_enable low, then IDLE.
- IDLE with rx_enable low for one cycle is required between packets. A new rx_enable on the same cycle the state returns to IDLE is accepted.
- icmp_rx_enable and udp_rx_enable are never high together.
- remote_ip is stable from the first payload enable until the next accepted header.

Decomposition:
- Shared package (ip_defs): IP version value 4, minimum IHL 5, protocol constants, header byte offsets (TOTLEN=2, PROTO=9, SRC=12, DST=16).
- One natural sub-module: ip_hdr_csum (byte-serial 16-bit word accumulator with clear, byte-index parity input and folded-result output). It is reusable by the transmit-side header builder.

Test Plan:
1. Ping, IHL=5, total_len=60, dst=local_ip, proto 1, valid checksum, 4 bytes of Ethernet padding -> icmp_rx_enable high exactly 40 cycles starting 21 cycles after the first byte; payload_data matches; remote_ip = src; udp_rx_enable 0.
2. Same packet with header byte 10 corrupted -> no enables; drop_count 0->1; hdr_error single pulse. Repeat with CHECK_HDR_CSUM=0 -> accepted.
3. UDP to 255.255.255.255, then ICMP to 255.255.255.255 -> UDP accepted with is_broadcast=1; ICMP silently discarded, drop_count unchanged.
4. IHL=6 with 4 option bytes, total_len=32 -> udp_rx_enable for 8 bytes starting at byte 24; option bytes not forwarded.
5. icmp_busy=1 during the decision byte -> packet dropped and counted; back-to-back packet with one idle cycle after busy clears -> accepted.
6. Assert reset at payload byte 5 -> enables 0 the next cycle; rest of packet ignored; next clean packet accepted. Also preload drop_count=16'hFFFF via 65535 drops (or force) and drop once more -> stays 16'hFFFF.

Source files
------------

// File: rtl/ip_rx_dispatch_pkg.sv
// Shared IPv4 receive definitions: header constants, field offsets and the
// ones-complement fold used by header checksum logic.
package ip_rx_dispatch_pkg;

  localparam logic [3:0] IP_VERSION = 4'd4;
  localparam logic [3:0] IP_MIN_IHL = 4'd5;
  localparam logic [7:0] PROTO_ICMP = 8'd1;
  localparam logic [7:0] PROTO_UDP  = 8'd17;

  localparam logic [5:0] OFS_TOTLEN  = 6'd2;
  localparam logic [5:0] OFS_PROTO   = 6'd9;
  localparam logic [5:0] OFS_SRC     = 6'd12;
  localparam logic [5:0] OFS_DST     = 6'd16;
  localparam logic [5:0] OFS_HDR_END = 6'd19;

  typedef enum logic [1:0] {
    VERDICT_ACCEPT = 2'd0,
    VERDICT_SILENT = 2'd1,
    VERDICT_DROP   = 2'd2
  } verdict_t;

  // Complemented end-around-carry fold; zero means the header sums correctly.
  function automatic logic [15:0] csum_fold(input logic [31:0] sum);
    logic [16:0] first_s;
    logic [15:0] second_s;
    first_s  = {1'b0, sum[15:0]} + {1'b0, sum[31:16]};
    second_s = first_s[15:0] + {15'd0, first_s[16]};
    return ~second_s;
  endfunction

endpackage

// File: rtl/ip_rx_dispatch_if.sv
// Byte stream into the dispatcher and the gated payload stream out to the
// ICMP and UDP responders, with their busy back-pressure.
interface ip_rx_dispatch_if;
  logic       rx_enable;
  logic [7:0] rx_data;
  logic       icmp_busy;
  logic       udp_busy;
  logic [7:0] payload_data;
  logic       icmp_rx_enable;
  logic       udp_rx_enable;

  modport master (
    output rx_enable, rx_data, icmp_busy, udp_busy,
    input  payload_data, icmp_rx_enable, udp_rx_enable
  );

  modport slave (
    input  rx_enable, rx_data, icmp_busy, udp_busy,
    output payload_data, icmp_rx_enable, udp_rx_enable
  );
endinterface

// File: rtl/ip_hdr_csum.sv
// Byte-serial IPv4 header checksum: even-index bytes are the high half of each
// 16-bit word; the folded result already includes the byte on the input.
module ip_hdr_csum
  import ip_rx_dispatch_pkg::*;
(
  input  logic        rx_clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic        odd,
  input  logic [7:0]  data,
  output logic [15:0] folded
);

  logic [31:0] acc_r;
  logic [31:0] sum_s;
  logic [7:0]  hi_r;

  // Running sum including the word completed by the current odd byte.
  always_comb begin
    sum_s = clear ? 32'd0 : acc_r;
    if (byte_en && odd) begin
      sum_s = sum_s + {16'd0, hi_r, data};
    end else begin
      sum_s = sum_s;
    end
    folded = csum_fold(sum_s);
  end

  // Accumulator and pending high byte.
  always_ff @(posedge rx_clock) begin
    if (reset) begin
      acc_r <= 32'd0;
      hi_r  <= 8'd0;
    end else begin
      if (byte_en || clear) acc_r <= sum_s;
      if (byte_en && !odd)  hi_r  <= data;
    end
  end

endmodule

// File: rtl/ip_rx_dispatch.sv
// IPv4 receive dispatcher: parses and validates the header, then forwards the
// payload (without Ethernet padding) to exactly one of the ICMP/UDP responders.
module ip_rx_dispatch
  import ip_rx_dispatch_pkg::*;
#(
  parameter logic [7:0] ICMP_PROTO     = 8'd1,
  parameter logic [7:0] UDP_PROTO      = 8'd17,
  parameter bit         CHECK_HDR_CSUM = 1'b1
) (
  input  logic              rx_clock,
  input  logic              reset,
  ip_rx_dispatch_if.slave   bus,
  input  logic [31:0]       local_ip,
  output logic [31:0]       remote_ip,
  output logic              is_broadcast,
  output logic [15:0]       drop_count,
  output logic              hdr_error
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HEADER  = 3'd1;
  localparam logic [2:0] ST_OPTIONS = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_DISCARD = 3'd4;

  logic [2:0]  state_r, state_nxt_s;
  logic [5:0]  hdr_cnt_r;
  logic [3:0]  ihl_r;
  logic [15:0] total_len_r, rem_r, drop_r;
  logic [7:0]  proto_r, payload_r;
  logic [31:0] src_r, dst_r, remote_ip_r, dst_eff_s;
  logic        sel_icmp_r, icmp_en_r, udp_en_r, bcast_r, hdr_err_r;
  logic        in_hdr_s, last_s, csum_ok_s, len_ok_s, dst_ok_s, proto_ok_s, busy_s;
  logic        accept_s, count_s, err_s, fwd_s;
  logic [15:0] folded_s;
  verdict_t    verdict_s;

  assign in_hdr_s = (state_r == ST_HEADER) || (state_r == ST_OPTIONS);
  assign last_s   = (hdr_cnt_r == {ihl_r - 4'd1, 2'b11});
  assign fwd_s    = (state_r == ST_PAYLOAD) && bus.rx_enable && (rem_r != 16'd0);

  ip_hdr_csum u_csum (
    .rx_clock (rx_clock),
    .reset    (reset),
    .clear    (state_r == ST_IDLE),
    .byte_en  (bus.rx_enable && ((state_r == ST_IDLE) || in_hdr_s)),
    .odd      (hdr_cnt_r[0] && in_hdr_s),
    .data     (bus.rx_data),
    .folded   (folded_s)
  );

  // Header verdict; the last destination byte is still on the bus when IHL is 5.
  always_comb begin
    if (hdr_cnt_r == OFS_HDR_END) dst_eff_s = {dst_r[23:0], bus.rx_data};
    else                          dst_eff_s = dst_r;
    csum_ok_s  = !CHECK_HDR_CSUM || (folded_s == 16'd0);
    len_ok_s   = total_len_r > {10'd0, ihl_r, 2'b00};
    dst_ok_s   = (dst_eff_s == local_ip) ||
                 ((dst_eff_s == 32'hFFFF_FFFF) && (proto_r == UDP_PROTO));
    proto_ok_s = (proto_r == ICMP_PROTO) || (proto_r == UDP_PROTO);
    busy_s     = (proto_r == ICMP_PROTO) ? bus.icmp_busy : bus.udp_busy;
    if (!csum_ok_s || !len_ok_s)      verdict_s = VERDICT_DROP;
    else if (!dst_ok_s || !proto_ok_s) verdict_s = VERDICT_SILENT;
    else if (busy_s)                   verdict_s = VERDICT_DROP;
    else                               verdict_s = VERDICT_ACCEPT;
  end

  // Next-state, drop-count and error-pulse decisions.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    count_s     = 1'b0;
    err_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!bus.rx_enable) begin
          state_nxt_s = ST_IDLE;
        end else if ((bus.rx_data[7:4] == IP_VERSION) && (bus.rx_data[3:0] >= IP_MIN_IHL)) begin
          state_nxt_s = ST_HEADER;
        end else begin
          state_nxt_s = ST_DISCARD;
          count_s     = 1'b1;
          err_s       = 1'b1;
        end
      end
      ST_HEADER, ST_OPTIONS: begin
        if (!bus.rx_enable) begin
          state_nxt_s = ST_IDLE;
          count_s     = 1'b1;
          err_s       = 1'b1;
        end else if (last_s) begin
          case (verdict_s)
            VERDICT_ACCEPT: begin
              state_nxt_s = ST_PAYLOAD;
              accept_s    = 1'b1;
            end
            VERDICT_SILENT: state_nxt_s = ST_DISCARD;
            default: begin
              state_nxt_s = ST_DISCARD;
              count_s     = 1'b1;
              err_s       = 1'b1;
            end
          endcase
        end else if (hdr_cnt_r == OFS_HDR_END) begin
          state_nxt_s = ST_OPTIONS;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_PAYLOAD: begin
        if (!bus.rx_enable)          state_nxt_s = ST_IDLE;
        else if (rem_r == 16'd0)     state_nxt_s = ST_DISCARD;
        else                         state_nxt_s = ST_PAYLOAD;
      end
      ST_DISCARD: begin
        if (!bus.rx_enable) state_nxt_s = ST_IDLE;
        else                state_nxt_s = ST_DISCARD;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, header fields, payload gating and status registers.
  always_ff @(posedge rx_clock) begin
    if (reset) begin
      state_r     <= bus.rx_enable ? ST_DISCARD : ST_IDLE;
      hdr_cnt_r   <= 6'd0;
      ihl_r       <= 4'd0;
      total_len_r <= 16'd0;
      proto_r     <= 8'd0;
      src_r       <= 32'd0;
      dst_r       <= 32'd0;
      rem_r       <= 16'd0;
      sel_icmp_r  <= 1'b0;
      icmp_en_r   <= 1'b0;
      udp_en_r    <= 1'b0;
      payload_r   <= 8'd0;
      remote_ip_r <= 32'd0;
      bcast_r     <= 1'b0;
      drop_r      <= 16'd0;
      hdr_err_r   <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      payload_r <= bus.rx_data;
      hdr_err_r <= err_s;
      icmp_en_r <= fwd_s && sel_icmp_r;
      udp_en_r  <= fwd_s && !sel_icmp_r;
      if (state_r == ST_IDLE && bus.rx_enable) begin
        ihl_r     <= bus.rx_data[3:0];
        hdr_cnt_r <= 6'd1;
      end else if (in_hdr_s && bus.rx_enable) begin
        hdr_cnt_r <= hdr_cnt_r + 6'd1;
        case (hdr_cnt_r)
          OFS_TOTLEN:         total_len_r[15:8] <= bus.rx_data;
          OFS_TOTLEN + 6'd1:  total_len_r[7:0]  <= bus.rx_data;
          OFS_PROTO:          proto_r           <= bus.rx_data;
          default: begin end
        endcase
        if (hdr_cnt_r >= OFS_SRC && hdr_cnt_r < OFS_DST)
          src_r <= {src_r[23:0], bus.rx_data};
        if (hdr_cnt_r >= OFS_DST && hdr_cnt_r <= OFS_HDR_END)
          dst_r <= {dst_r[23:0], bus.rx_data};
      end
      if (accept_s) begin
        rem_r       <= total_len_r - {10'd0, ihl_r, 2'b00};
        sel_icmp_r  <= (proto_r == ICMP_PROTO);
        remote_ip_r <= src_r;
        bcast_r     <= (dst_eff_s == 32'hFFFF_FFFF);
      end else if (fwd_s) begin
        rem_r <= rem_r - 16'd1;
      end
      if (count_s && drop_r != 16'hFFFF) drop_r <= drop_r + 16'd1;
    end
  end

  assign bus.payload_data   = payload_r;
  assign bus.icmp_rx_enable = icmp_en_r;
  assign bus.udp_rx_enable  = udp_en_r;
  assign remote_ip          = remote_ip_r;
  assign is_broadcast       = bcast_r;
  assign drop_count         = drop_r;
  assign hdr_error          = hdr_err_r;

endmodule

// File: tb/tb_ip_rx_dispatch.sv
// Scoreboard bench for ip_rx_dispatch: expected payload bytes are queued while
// driving and popped whenever a responder enable is seen.
module tb_ip_rx_dispatch;

  typedef struct packed {
    logic [7:0] data;
    logic       icmp;
  } exp_t;

  logic        rx_clock = 1'b0;
  logic        reset;
  logic [31:0] local_ip;
  logic [31:0] remote_ip, remote_ip2;
  logic        is_broadcast, is_broadcast2, hdr_error, hdr_error2;
  logic [15:0] drop_count, drop_count2;

  ip_rx_dispatch_if bus ();
  ip_rx_dispatch_if bus2 ();

  assign bus2.rx_enable = bus.rx_enable;
  assign bus2.rx_data   = bus.rx_data;
  assign bus2.icmp_busy = bus.icmp_busy;
  assign bus2.udp_busy  = bus.udp_busy;

  ip_rx_dispatch #(.CHECK_HDR_CSUM(1'b1)) dut (
    .rx_clock(rx_clock), .reset(reset), .bus(bus), .local_ip(local_ip),
    .remote_ip(remote_ip), .is_broadcast(is_broadcast),
    .drop_count(drop_count), .hdr_error(hdr_error));

  ip_rx_dispatch #(.CHECK_HDR_CSUM(1'b0)) dut_nocsum (
    .rx_clock(rx_clock), .reset(reset), .bus(bus2), .local_ip(local_ip),
    .remote_ip(remote_ip2), .is_broadcast(is_broadcast2),
    .drop_count(drop_count2), .hdr_error(hdr_error2));

  always #5 rx_clock = ~rx_clock;

  int   checks, errors, cyc;
  int   en_count, en2_count, err_pulses, rise_cyc;
  int   en_base, en2_base, err_base, start_cyc;
  logic prev_en = 1'b0;
  exp_t exp_q[$];

  logic [7:0] pkt [0:95];
  int         pkt_len, pkt_total, pkt_hdr;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge rx_clock) cyc <= cyc + 1;

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge rx_clock) begin
    logic cur;
    exp_t e;
    cur = bus.icmp_rx_enable || bus.udp_rx_enable;
    if (bus.icmp_rx_enable && bus.udp_rx_enable) check_value("enable_exclusive", 32'd1, 32'd0);
    if (cur) begin
      en_count++;
      if (!prev_en) rise_cyc = cyc;
      if (exp_q.size() == 0) begin
        check_value("unexpected_enable", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_value("payload_data", {24'd0, bus.payload_data}, {24'd0, e.data});
        check_value("enable_select", {31'd0, bus.icmp_rx_enable}, {31'd0, e.icmp});
      end
    end
    prev_en = cur;
    if (bus2.icmp_rx_enable || bus2.udp_rx_enable) en2_count++;
    if (hdr_error) err_pulses++;
  end

  task automatic build_pkt(input logic [3:0] ihl, input logic [15:0] tlen, input logic [7:0] proto,
                           input logic [31:0] src, input logic [31:0] dst, input int pad);
    logic [31:0] s;
    logic [15:0] cs;
    pkt_hdr   = ihl * 4;
    pkt_total = tlen;
    pkt_len   = tlen + pad;
    for (int i = 0; i < pkt_len; i++) pkt[i] = 8'($urandom_range(0, 255));
    pkt[0] = {4'd4, ihl};
    pkt[1] = 8'd0;
    pkt[2] = tlen[15:8];
    pkt[3] = tlen[7:0];
    pkt[8] = 8'd64;
    pkt[9] = proto;
    pkt[10] = 8'd0;
    pkt[11] = 8'd0;
    for (int b = 0; b < 4; b++) begin
      pkt[12 + b] = src[31 - 8*b -: 8];
      pkt[16 + b] = dst[31 - 8*b -: 8];
    end
    s = 32'd0;
    for (int w = 0; w < pkt_hdr / 2; w++) s = s + {16'd0, pkt[2*w], pkt[2*w + 1]};
    while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    cs = ~s[15:0];
    pkt[10] = cs[15:8];
    pkt[11] = cs[7:0];
  endtask

  task automatic send_pkt(input bit exp_acc, input bit exp_icmp, input int reset_idx);
    en_base  = en_count;
    en2_base = en2_count;
    err_base = err_pulses;
    for (int i = 0; i < pkt_len; i++) begin
      bus.rx_enable = 1'b1;
      bus.rx_data   = pkt[i];
      reset         = (i == reset_idx);
      if (i == 0) start_cyc = cyc;
      if (exp_acc && i >= pkt_hdr && i < pkt_total && (reset_idx < 0 || i < reset_idx))
        exp_q.push_back({pkt[i], exp_icmp});
      @(posedge rx_clock); #1;
    end
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.rx_enable = 1'b0;
    bus.rx_data   = 8'd0;
    repeat (n) begin @(posedge rx_clock); #1; end
  endtask

  task automatic check_pkt(input string pfx, input int exp_en, input int exp_rise,
                           input int exp_err, input logic [15:0] exp_drop);
    check_value({pfx, "_en_count"}, en_count - en_base, exp_en);
    if (exp_en > 0) check_value({pfx, "_en_start"}, rise_cyc - start_cyc, exp_rise);
    check_value({pfx, "_hdr_error"}, err_pulses - err_base, exp_err);
    check_value({pfx, "_drop_count"}, {16'd0, drop_count}, {16'd0, exp_drop});
    check_value({pfx, "_drained"}, exp_q.size(), 32'd0);
  endtask

  localparam logic [31:0] LOCAL = 32'hC0A8_0064;

  initial begin
    reset = 1'b1;
    local_ip = LOCAL;
    bus.icmp_busy = 1'b0;
    bus.udp_busy  = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(1);
    check_value("rst_icmp_en", {31'd0, bus.icmp_rx_enable}, 32'd0);
    check_value("rst_udp_en", {31'd0, bus.udp_rx_enable}, 32'd0);
    check_value("rst_payload", {24'd0, bus.payload_data}, 32'd0);
    check_value("rst_remote_ip", remote_ip, 32'd0);
    check_value("rst_bcast", {31'd0, is_broadcast}, 32'd0);
    check_value("rst_drop", {16'd0, drop_count}, 32'd0);
    check_value("rst_hdr_err", {31'd0, hdr_error}, 32'd0);

    // Ping with padding.
    build_pkt(4'd5, 16'd60, 8'd1, 32'h0A00_0002, LOCAL, 4);
    send_pkt(1'b1, 1'b1, -1); idle(4);
    check_pkt("t1", 40, 21, 0, 16'd0);
    check_value("t1_remote_ip", remote_ip, 32'h0A00_0002);
    check_value("t1_bcast", {31'd0, is_broadcast}, 32'd0);
    check_value("t1_nocsum_en", en2_count - en2_base, 32'd40);

    // Corrupted header byte 10.
    build_pkt(4'd5, 16'd60, 8'd1, 32'h0A00_00F2, LOCAL, 4);
    pkt[10] = pkt[10] ^ 8'h01;
    send_pkt(1'b0, 1'b0, -1); idle(4);
    check_pkt("t2", 0, 0, 1, 16'd1);
    check_value("t2_remote_ip", remote_ip, 32'h0A00_0002);
    check_value("t2_nocsum_en", en2_count - en2_base, 32'd40);

    // UDP broadcast accepted, ICMP broadcast silently dropped.
    build_pkt(4'd5, 16'd60, 8'd17, 32'h0A00_0003, 32'hFFFF_FFFF, 4);
    send_pkt(1'b1, 1'b0, -1); idle(4);
    check_pkt("t3u", 40, 21, 0, 16'd1);
    check_value("t3u_bcast", {31'd0, is_broadcast}, 32'd1);
    check_value("t3u_remote_ip", remote_ip, 32'h0A00_0003);
    build_pkt(4'd5, 16'd60, 8'd1, 32'h0A00_0004, 32'hFFFF_FFFF, 4);
    send_pkt(1'b0, 1'b0, -1); idle(4);
    check_pkt("t3i", 0, 0, 0, 16'd1);
    check_value("t3i_remote_ip", remote_ip, 32'h0A00_0003);

    // Header with options.
    build_pkt(4'd6, 16'd32, 8'd17, 32'h0A00_0005, LOCAL, 28);
    send_pkt(1'b1, 1'b0, -1); idle(4);
    check_pkt("t4", 8, 25, 0, 16'd1);
    check_value("t4_bcast", {31'd0, is_broadcast}, 32'd0);

    // Busy responder, then back-to-back after one idle cycle.
    bus.icmp_busy = 1'b1;
    build_pkt(4'd5, 16'd60, 8'd1, 32'h0A00_0006, LOCAL, 4);
    send_pkt(1'b0, 1'b0, -1);
    bus.icmp_busy = 1'b0;
    idle(1);
    check_pkt("t5b", 0, 0, 1, 16'd2);
    build_pkt(4'd5, 16'd60, 8'd1, 32'h0A00_0007, LOCAL, 4);
    send_pkt(1'b1, 1'b1, -1); idle(4);
    check_pkt("t5a", 40, 21, 0, 16'd2);
    check_value("t5a_remote_ip", remote_ip, 32'h0A00_0007);

    // Reset at payload byte 5, then a clean packet.
    build_pkt(4'd5, 16'd60, 8'd1, 32'h0A00_0008, LOCAL, 4);
    send_pkt(1'b1, 1'b1, 25); idle(4);
    check_pkt("t6r", 5, 21, 0, 16'd0);
    check_value("t6r_remote_ip", remote_ip, 32'd0);
    build_pkt(4'd5, 16'd60, 8'd1, 32'h0A00_0009, LOCAL, 4);
    send_pkt(1'b1, 1'b1, -1); idle(4);
    check_pkt("t6c", 40, 21, 0, 16'd0);
    check_value("t6c_remote_ip", remote_ip, 32'h0A00_0009);

    // Drop counter saturation.
    @(negedge rx_clock);
    force dut.drop_r = 16'hFFFE;
    @(negedge rx_clock);
    release dut.drop_r;
    @(posedge rx_clock); #1;
    check_value("t7_preload", {16'd0, drop_count}, 32'h0000_FFFE);
    pkt[0] = 8'h65; pkt_len = 1; pkt_total = 1; pkt_hdr = 20;
    send_pkt(1'b0, 1'b0, -1); idle(3);
    check_pkt("t7a", 0, 0, 1, 16'hFFFF);
    send_pkt(1'b0, 1'b0, -1); idle(3);
    check_pkt("t7b", 0, 0, 1, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
